// File: rtl/mem_arbiter_mc.sv
`timescale 1ns/1ps
// mem_arbiter_mc: arbitrates N requesters onto one byte-serial RAM/IO bus and
// splits 1/2/4-byte reads and writes into single-byte accesses.
module mem_arbiter_mc #(
  parameter int                NUM_CH   = 2,
  parameter int                ARB_MODE = 1,
  parameter logic [NUM_CH-1:0] CLR_MASK = {NUM_CH{1'b1}}
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rdy,
  input  logic                 i_clear,
  input  logic [NUM_CH-1:0]    i_req_valid,
  input  logic [NUM_CH-1:0]    i_req_wr,
  input  logic [2*NUM_CH-1:0]  i_req_size,
  input  logic [32*NUM_CH-1:0] i_req_addr,
  input  logic [32*NUM_CH-1:0] i_req_wdata,
  output logic [NUM_CH-1:0]    o_resp_valid,
  output logic [31:0]          o_resp_data,
  output logic                 o_busy,
  input  logic [7:0]           i_mem_din,
  output logic [7:0]           o_mem_dout,
  output logic [31:0]          o_mem_a,
  output logic                 o_mem_wr,
  input  logic                 i_io_buffer_full
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_ptr;
  logic [CW-1:0]      r_g;
  logic               r_wr;
  logic [2:0]         r_n;
  logic [2:0]         r_cnt;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [31:0]        r_mem_a;
  logic [31:0]        r_resp_data;
  logic [7:0]         r_mem_dout;
  logic               r_mem_wr;
  logic [NUM_CH-1:0]  r_resp_valid;

  logic [NUM_CH-1:0]  w_elig;
  logic [CW-1:0]      w_grant;
  logic               w_grant_ok;
  logic [NUM_CH-1:0]  w_grant_oh;
  logic [NUM_CH-1:0]  w_g_oh;
  logic               w_sel_wr;
  logic [1:0]         w_sel_size;
  logic [31:0]        w_sel_addr;
  logic [31:0]        w_sel_wdata;
  logic [2:0]         w_cnt_nxt;
  logic [1:0]         w_cap_b;
  logic               w_stall;
  logic               w_abort;
  logic [31:0]        w_mem_a;

  function automatic logic [2:0] size_bytes(input logic [1:0] s);
    case (s)
      2'd0:    size_bytes = 3'd1;
      2'd1:    size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] k);
    get_byte = w[{k, 3'b000} +: 8];
  endfunction

  // Masked channels drop out of arbitration while a flush is requested
  always_comb begin
    if (i_clear) begin
      w_elig = i_req_valid & ~CLR_MASK;
    end else begin
      w_elig = i_req_valid;
    end
  end

  assign w_grant_ok = |w_elig;

  // Grant selection; the closest eligible channel wins, so loops run from the far end
  always_comb begin
    w_grant = '0;
    if (ARB_MODE == 0) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (w_elig[i]) w_grant = CW'(i);
        else           w_grant = w_grant;
      end
    end else begin
      for (int k = NUM_CH; k >= 1; k--) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (w_elig[i] && (((int'(r_ptr) + k) % NUM_CH) == i)) w_grant = CW'(i);
          else                                               w_grant = w_grant;
        end
      end
    end
  end

  // One-hot decode of the new grant and the latched grant, plus request field mux
  always_comb begin
    w_sel_wr    = 1'b0;
    w_sel_size  = 2'd0;
    w_sel_addr  = 32'd0;
    w_sel_wdata = 32'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_grant_oh[i] = (w_grant == CW'(i));
      w_g_oh[i]     = (r_g == CW'(i));
      w_sel_wr      = w_sel_wr | (i_req_wr[i] & w_grant_oh[i]);
      w_sel_size    = w_sel_size | (i_req_size[2*i +: 2] & {2{w_grant_oh[i]}});
      w_sel_addr    = w_sel_addr | (i_req_addr[32*i +: 32] & {32{w_grant_oh[i]}});
      w_sel_wdata   = w_sel_wdata | (i_req_wdata[32*i +: 32] & {32{w_grant_oh[i]}});
    end
  end

  assign w_cnt_nxt = r_cnt + 3'd1;
  assign w_cap_b   = r_cnt[1:0] - 2'd1;
  assign w_stall   = (r_mem_a[17:16] == 2'b11) && i_io_buffer_full;
  assign w_abort   = i_rdy && i_clear && !r_wr && (|(w_g_oh & CLR_MASK)) &&
                     ((r_state == S_RD) || (r_state == S_DONE));

  // While frozen mid-read, keep presenting the byte whose data is still owed,
  // so mem_din is valid again in the first cycle rdy returns
  always_comb begin
    if (!i_rdy && (r_state == S_RD) && (r_cnt != 3'd0)) begin
      w_mem_a = r_addr + {30'd0, w_cap_b};
    end else begin
      w_mem_a = r_mem_a;
    end
  end

  assign o_mem_a      = w_mem_a;
  assign o_mem_dout   = r_mem_dout;
  assign o_mem_wr     = r_mem_wr && i_rdy && !w_stall;
  assign o_resp_data  = r_resp_data;
  assign o_resp_valid = r_resp_valid & ~{NUM_CH{w_abort}};
  assign o_busy       = (r_state != S_IDLE);

  // Main sequencer: grant, byte serialisation, completion pulse
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_ptr        <= CW'(NUM_CH - 1);
      r_g          <= '0;
      r_wr         <= 1'b0;
      r_n          <= 3'd1;
      r_cnt        <= 3'd0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_mem_a      <= 32'd0;
      r_resp_data  <= 32'd0;
      r_mem_dout   <= 8'd0;
      r_mem_wr     <= 1'b0;
      r_resp_valid <= '0;
    end else if (i_rdy) begin
      case (r_state)
        S_IDLE: begin
          r_resp_valid <= '0;
          if (w_grant_ok) begin
            r_g        <= w_grant;
            r_ptr      <= w_grant;
            r_wr       <= w_sel_wr;
            r_n        <= size_bytes(w_sel_size);
            r_addr     <= w_sel_addr;
            r_wdata    <= w_sel_wdata;
            r_cnt      <= 3'd0;
            r_mem_a    <= w_sel_addr;
            r_mem_wr   <= w_sel_wr;
            r_mem_dout <= w_sel_wdata[7:0];
            r_state    <= w_sel_wr ? S_WR : S_RD;
            if (!w_sel_wr) r_resp_data <= 32'd0;
          end else begin
            r_mem_wr <= 1'b0;
          end
        end
        S_RD: begin
          if (w_abort) begin
            r_state <= S_IDLE;
          end else begin
            if (r_cnt != 3'd0) r_resp_data[{w_cap_b, 3'b000} +: 8] <= i_mem_din;
            if (w_cnt_nxt < r_n) r_mem_a <= r_mem_a + 32'd1;
            if (r_cnt == r_n) begin
              r_state      <= S_DONE;
              r_resp_valid <= w_g_oh;
            end
            r_cnt <= w_cnt_nxt;
          end
        end
        S_WR: begin
          if (!w_stall) begin
            if (w_cnt_nxt < r_n) begin
              r_mem_a    <= r_mem_a + 32'd1;
              r_mem_dout <= get_byte(r_wdata, w_cnt_nxt[1:0]);
              r_cnt      <= w_cnt_nxt;
            end else begin
              r_state      <= S_DONE;
              r_resp_valid <= w_g_oh;
              r_mem_wr     <= 1'b0;
            end
          end
        end
        S_DONE: begin
          r_state      <= S_IDLE;
          r_resp_valid <= '0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_mc.sv
`timescale 1ns/1ps
// tb_mem_arbiter_mc: directed stimulus with queued expectations; a negedge
// monitor compares bus writes, completion pulses and scheduled output probes.
module tb_mem_arbiter_mc;

  logic        clk = 1'b0;
  logic        rst, rdy, clear, io_full;
  logic [1:0]  req_valid, req_wr;
  logic [3:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  resp_valid;
  logic [31:0] resp_data;
  logic        busy;
  logic [7:0]  mem_din = 8'd0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  always #5 clk = ~clk;

  mem_arbiter_mc #(.NUM_CH(2), .ARB_MODE(1), .CLR_MASK(2'b01)) dut (
    .i_clk(clk), .i_rst(rst), .i_rdy(rdy), .i_clear(clear),
    .i_req_valid(req_valid), .i_req_wr(req_wr), .i_req_size(req_size),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_resp_valid(resp_valid), .o_resp_data(resp_data), .o_busy(busy),
    .i_mem_din(mem_din), .o_mem_dout(mem_dout), .o_mem_a(mem_a),
    .o_mem_wr(mem_wr), .i_io_buffer_full(io_full)
  );

  typedef struct { int cyc; int ch; logic [31:0] data; bit chk_data; } resp_t;
  typedef struct { int cyc; logic [31:0] addr; logic [7:0] data; } wr_t;
  typedef struct { int cyc; int kind; logic [31:0] val; } pt_t;

  resp_t rq[$];
  wr_t   wq[$];
  pt_t   pq[$];

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  bit end_chk = 1'b0;
  bit chk_done = 1'b0;
  int t0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    case (a)
      32'h100: ram_rd = 8'h11;
      32'h101: ram_rd = 8'h22;
      32'h102: ram_rd = 8'h33;
      32'h103: ram_rd = 8'h44;
      default: ram_rd = a[7:0] + 8'h01;
    endcase
  endfunction

  // RAM answers the address presented in the previous cycle
  always @(posedge clk) mem_din <= ram_rd(mem_a);

  function automatic logic [31:0] probe(input int k);
    case (k)
      0:       probe = mem_a;
      1:       probe = {24'd0, mem_dout};
      2:       probe = {31'd0, mem_wr};
      3:       probe = {31'd0, busy};
      4:       probe = resp_data;
      default: probe = {30'd0, resp_valid};
    endcase
  endfunction

  function automatic string kname(input int k);
    case (k)
      0:       kname = "mem_a";
      1:       kname = "mem_dout";
      2:       kname = "mem_wr";
      3:       kname = "busy";
      4:       kname = "resp_data";
      default: kname = "resp_valid";
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%08h expected 0x%08h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a write, a pulse, or a probe is due
  always @(negedge clk) begin
    pt_t   p;
    resp_t r;
    wr_t   w;
    if (!end_chk) begin
      while (pq.size() > 0 && pq[0].cyc <= cyc) begin
        p = pq.pop_front();
        check($sformatf("%s@%0d", kname(p.kind), p.cyc), probe(p.kind), p.val);
      end
      if (resp_valid != 2'b00) begin
        if (rq.size() == 0) begin
          check("resp_valid with none pending", {30'd0, resp_valid}, 32'd0);
        end else begin
          r = rq.pop_front();
          check("resp channel", {30'd0, resp_valid}, (r.ch == 0) ? 32'd1 : 32'd2);
          check("resp cycle", cyc, r.cyc);
          if (r.chk_data) check("resp data", resp_data, r.data);
        end
      end
      if (mem_wr) begin
        if (wq.size() == 0) begin
          check("mem_wr with no write pending", {31'd0, mem_wr}, 32'd0);
        end else begin
          w = wq.pop_front();
          check("write cycle", cyc, w.cyc);
          check("write addr", mem_a, w.addr);
          check("write byte", {24'd0, mem_dout}, {24'd0, w.data});
        end
      end
    end else if (!chk_done) begin
      check("resp queue left over", rq.size(), 32'd0);
      check("write queue left over", wq.size(), 32'd0);
      check("probe queue left over", pq.size(), 32'd0);
      chk_done = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic push_pt(input int c, input int k, input logic [31:0] v);
    pt_t p;
    p.cyc = c; p.kind = k; p.val = v;
    pq.push_back(p);
  endtask

  task automatic push_resp(input int c, input int ch, input logic [31:0] d, input bit chk);
    resp_t r;
    r.cyc = c; r.ch = ch; r.data = d; r.chk_data = chk;
    rq.push_back(r);
  endtask

  task automatic push_wr(input int c, input logic [31:0] a, input logic [7:0] d);
    wr_t w;
    w.cyc = c; w.addr = a; w.data = d;
    wq.push_back(w);
  endtask

  task automatic set_req(input int ch, input bit wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
    if (ch == 0) begin
      req_valid[0] = 1'b1; req_wr[0] = wr; req_size[1:0] = sz;
      req_addr[31:0] = a; req_wdata[31:0] = wd;
    end else begin
      req_valid[1] = 1'b1; req_wr[1] = wr; req_size[3:2] = sz;
      req_addr[63:32] = a; req_wdata[63:32] = wd;
    end
  endtask

  task automatic drop_req(input int ch);
    if (ch == 0) req_valid[0] = 1'b0;
    else         req_valid[1] = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) push_pt(cyc, k, 32'd0);
    step();
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; clear = 1'b0; io_full = 1'b0;
    req_valid = 2'b00; req_wr = 2'b00; req_size = 4'd0;
    req_addr = 64'd0; req_wdata = 64'd0;

    // Word read on ch0: bytes 11,22,33,44 assembled little-endian, pulse at T+6
    reset_dut();
    t0 = cyc;
    set_req(0, 1'b0, 2'd2, 32'h0000_0100, 32'd0);
    push_pt(t0 + 1, 0, 32'h0000_0100);
    push_pt(t0 + 1, 3, 32'd1);
    push_pt(t0 + 2, 0, 32'h0000_0101);
    push_pt(t0 + 3, 0, 32'h0000_0102);
    push_pt(t0 + 4, 0, 32'h0000_0103);
    push_resp(t0 + 6, 0, 32'h4433_2211, 1'b1);
    wait_until(t0 + 7);
    drop_req(0);

    // Round-robin: both channels keep requesting byte reads -> 0,1,0,1
    reset_dut();
    t0 = cyc;
    set_req(0, 1'b0, 2'd0, 32'h0000_0010, 32'd0);
    set_req(1, 1'b0, 2'd0, 32'h0000_0021, 32'd0);
    push_resp(t0 + 3,  0, 32'h0000_0011, 1'b1);
    push_resp(t0 + 7,  1, 32'h0000_0022, 1'b1);
    push_resp(t0 + 11, 0, 32'h0000_0011, 1'b1);
    push_resp(t0 + 15, 1, 32'h0000_0022, 1'b1);
    wait_until(t0 + 16);
    drop_req(0);
    drop_req(1);

    // Half write 0xBEEF to 0x200
    reset_dut();
    t0 = cyc;
    set_req(0, 1'b1, 2'd1, 32'h0000_0200, 32'h0000_BEEF);
    push_wr(t0 + 1, 32'h0000_0200, 8'hEF);
    push_wr(t0 + 2, 32'h0000_0201, 8'hBE);
    push_resp(t0 + 3, 0, 32'd0, 1'b0);
    wait_until(t0 + 4);
    drop_req(0);

    // IO byte write held off by a full UART for 5 cycles
    reset_dut();
    t0 = cyc;
    set_req(0, 1'b1, 2'd0, 32'h0003_0000, 32'h0000_0041);
    push_pt(t0 + 3, 0, 32'h0003_0000);
    push_wr(t0 + 6, 32'h0003_0000, 8'h41);
    push_resp(t0 + 7, 0, 32'd0, 1'b0);
    step();
    io_full = 1'b1;
    wait_until(t0 + 6);
    io_full = 1'b0;
    wait_until(t0 + 8);
    drop_req(0);

    // Flush aborts the ch0 read; the unmasked ch1 write then runs to completion
    reset_dut();
    t0 = cyc;
    set_req(0, 1'b0, 2'd2, 32'h0000_0100, 32'd0);
    set_req(1, 1'b1, 2'd1, 32'h0000_0300, 32'h0000_CAFE);
    push_pt(t0 + 3, 3, 32'd1);
    push_pt(t0 + 4, 3, 32'd0);
    push_wr(t0 + 5, 32'h0000_0300, 8'hFE);
    push_wr(t0 + 6, 32'h0000_0301, 8'hCA);
    push_resp(t0 + 7, 1, 32'd0, 1'b0);
    wait_until(t0 + 3);
    clear = 1'b1;
    drop_req(0);
    step();
    clear = 1'b0;
    wait_until(t0 + 8);
    drop_req(1);

    // rdy low for T+2..T+4 stretches a word read by exactly 3 cycles
    reset_dut();
    t0 = cyc;
    set_req(0, 1'b0, 2'd2, 32'h0000_0100, 32'd0);
    push_pt(t0 + 6, 3, 32'd1);
    push_resp(t0 + 9, 0, 32'h4433_2211, 1'b1);
    wait_until(t0 + 2);
    rdy = 1'b0;
    wait_until(t0 + 5);
    rdy = 1'b1;
    wait_until(t0 + 10);
    drop_req(0);

    // Reset in the middle of a half write abandons the second byte
    step();
    t0 = cyc;
    set_req(1, 1'b1, 2'd1, 32'h0000_0500, 32'h0000_1234);
    push_wr(t0 + 1, 32'h0000_0500, 8'h34);
    push_pt(t0 + 2, 0, 32'd0);
    push_pt(t0 + 2, 2, 32'd0);
    push_pt(t0 + 2, 3, 32'd0);
    push_pt(t0 + 2, 5, 32'd0);
    step();
    rst = 1'b1;
    drop_req(1);
    step();
    rst = 1'b0;
    repeat (4) step();

    end_chk = 1'b1;
    for (int i = 0; i < 20 && !chk_done; i++) step();
    if (!chk_done) begin
      $display("FAIL monitor: final queue check never ran");
      $fatal(1, "monitor stalled");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_mc.md
Name: mem_arbiter_mc

Overview:
- Parametrised multi-channel memory controller between N requesters (fetch, LSB, future prefetch/second LSB port) and the single byte-serial RAM/IO bus.
- Arbitrates requests by fixed priority or round-robin.
- Serialises 1/2/4-byte reads and writes into byte accesses.
- Honours UART back-pressure, the global rdy freeze, and ROB clear flush with a per-channel abort mask.

Parameters:
NUM_CH, 2, number of request channels (1..8); channel 0 is lowest index.
ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin.
CLR_MASK, {NUM_CH{1'b1}}, bit i = 1: channel i reads are aborted by clear.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rdy  in  1  global ready; low freezes all state
clear  in  1  ROB misprediction flush
req_valid  in  NUM_CH  per-channel request level; held until that channel's resp_valid
req_wr  in  NUM_CH  1 = write
req_size  in  2*NUM_CH  0 byte, 1 half, 2 word, 3 treated as word
req_addr  in  32*NUM_CH  byte address of byte 0
req_wdata  in  32*NUM_CH  write data; byte k = bits [8k+7:8k]
resp_valid  out  NUM_CH  one-cycle completion pulse (read data valid / write done)
resp_data  out  32  shared read data, zero-extended; valid with any resp_valid bit
busy  out  1  state != IDLE
mem_din  in  8  RAM byte returned for the address presented in the previous cycle
mem_dout  out  8  write byte
mem_a  out  32  byte address
mem_wr  out  1  1 = write
io_buffer_full  in  1  UART TX full

Behaviour:
- Reset values:
  - state IDLE; mem_a, mem_dout, mem_wr = 0.
  - resp_valid = 0, resp_data = 0, busy = 0.
  - Round-robin pointer = NUM_CH-1, so channel 0 is first.
- States: IDLE, RD, WR, DONE.
- IDLE, any unmasked req_valid in cycle T:
  - Grant channel g; latch wr, size n (1/2/4 bytes), addr, wdata.
  - Go to RD or WR.
  - Same edge: register mem_a = addr, mem_wr = wr, mem_dout = byte 0.
- No requests in IDLE: mem_wr = 0; mem_a holds its last value.
- Arbitration:
  - ARB_MODE 0: lowest index wins.
  - ARB_MODE 1: search starts at pointer+1 mod NUM_CH; pointer <= g on every grant.
- RD:
  - Addresses addr+0 .. addr+n-1 are presented in cycles T+1..T+n.
  - Byte k is captured from mem_din in cycle T+k+2 into resp_data[8k+7:8k]; unused upper bytes are 0.
  - After the last capture, go to DONE.
  - Word read: resp_valid[g] high in cycle T+6; byte read: T+3.
- WR:
  - Byte k is presented with mem_wr = 1 in cycle T+1+k.
  - After the last byte, go to DONE; resp_valid[g] high in cycle T+n+1.
- IO write stall, mem_a[17:16] == 2'b11:
  - While io_buffer_full = 1, the current byte is not issued (mem_wr driven 0) and the sequence holds.
  - The byte is issued in the first cycle io_buffer_full = 0.
- DONE:
  - resp_valid[g] = 1 for exactly one cycle; no grant in this cycle.
  - Next state is IDLE.
  - The requester deasserts req_valid at the edge ending DONE.
  - Back-to-back requests therefore have one dead IDLE-sampling gap.
- Address arithmetic is 32-bit modulo; no alignment check; a word at 0x1FFFE spans 0x1FFFE..0x20001 unchanged.
- rdy = 0:
  - state, counters, latches, pointer and resp_valid are frozen.
  - mem_wr output is gated to 0; the pending byte is re-presented when rdy returns.
  - Read capture is skipped in frozen cycles.
- clear = 1 (with rdy = 1):
  - Masked channels are excluded from arbitration this cycle.
  - A read in RD or DONE for a masked g returns to IDLE next cycle; resp_valid is suppressed (0 in that cycle).
  - Writes are never aborted and complete normally.
  - Unmasked channels are unaffected.
- rst mid-transaction: immediate return to reset values; a partial write sequence is abandoned.
- Simultaneous clear and resp on a masked read: clear wins; no pulse.

Test Plan:
- NUM_CH=2, ARB_MODE=0: ch0 word read 0x100 with RAM bytes 11,22,33,44 -> mem_a 0x100..0x103 in T+1..T+4; resp_valid[0] at T+6; resp_data = 0x44332211.
- ARB_MODE=1: ch0 and ch1 permanently requesting byte reads -> grants alternate 0,1,0,1; each pulse lands only on its own channel.
- Half write 0xBEEF to 0x200 -> mem_wr=1 with (0x200,EF) then (0x201,BE); resp_valid pulse in the cycle after the last byte.
- Byte write 0x41 to 0x30000 with io_buffer_full high for 5 cycles -> mem_wr stays 0 for those 5 cycles; byte written in the first cycle full is low; exactly one write.
- Word read on masked ch0 with clear pulsed at T+3 -> IDLE at T+4, no resp_valid[0]; a concurrent ch1 write (mask bit 0) completes with its ack.
- Word read with rdy low at T+2..T+4 -> resp_valid delayed exactly 3 cycles to T+9; data correct; mem_wr never high.
